// File: rtl/tx_frame_loader.sv
// tx_frame_loader: buffers producer words in a FIFO and loads them as 4-word frames into TX registers A..D,
// then holds transmit until TX reports sent_n or a timeout aborts the frame.
module tx_frame_loader #(
    parameter int WORD_W     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ldA,
    output logic              ldB,
    output logic              ldC,
    output logic              ldD,
    output logic [WORD_W-1:0] ld_data,
    output logic              transmit,
    input  logic              sent_n,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_SENT, RELEASE} state_t;

    state_t            state, state_n;
    logic [1:0]        idx, idx_n;
    logic [TW-1:0]     tcnt;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop, done, expire, transmit_n, busy_n;
    logic [3:0]        ld_n;

    assign in_ready = !clr && count < CW'(FIFO_DEPTH);
    assign push     = in_valid && in_ready;
    assign done     = state == WAIT_SENT && !sent_n;
    assign expire   = state == WAIT_SENT && sent_n && tcnt == TW'(TIMEOUT - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = count >= CW'(4) ? LOAD : IDLE;
            LOAD:      state_n = idx == 2'd3 ? START : LOAD;
            START:     state_n = WAIT_SENT;
            WAIT_SENT: state_n = (done || expire) ? RELEASE : WAIT_SENT;
            default:   state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes line up with the state they belong to.
    always_comb begin
        pop        = state_n == LOAD;
        idx_n      = state == LOAD ? idx + 2'd1 : 2'd0;
        ld_n       = pop ? 4'b0001 << idx_n : 4'b0000;
        transmit_n = state_n == START || state_n == WAIT_SENT;
        busy_n     = state_n != IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state               <= IDLE;
            idx                 <= '0;
            tcnt                <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            {ldD, ldC, ldB, ldA} <= '0;
            ld_data             <= '0;
            transmit            <= 1'b0;
            busy                <= 1'b0;
            frame_cnt           <= '0;
            timeout_err         <= 1'b0;
        end else begin
            state               <= state_n;
            idx                 <= idx_n;
            tcnt                <= state == WAIT_SENT ? tcnt + 1'b1 : '0;
            wr_ptr              <= wr_ptr + AW'(push);
            rd_ptr              <= rd_ptr + AW'(pop);
            count               <= count + CW'(push) - CW'(pop);
            {ldD, ldC, ldB, ldA} <= ld_n;
            ld_data             <= pop ? mem[rd_ptr] : ld_data;
            transmit            <= transmit_n;
            busy                <= busy_n;
            frame_cnt           <= frame_cnt + 8'(done);
            timeout_err         <= timeout_err || expire;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule
